// File: rtl/key_bank_if.sv
// key_bank_if: key pins in, debounced levels and event pulses out.
// Signals:
//   i_in    raw key pins (async to the block clock)
//   o_level debounced pressed state per channel
//   o_neg   one-cycle pulse on accepted press
//   o_pos   one-cycle pulse on accepted release
//   o_long  one-cycle pulse when a press has been held long enough
//   o_rpt   one-cycle auto-repeat pulse during a long hold
//   o_any   OR of o_level
// master: the side that drives the pins. slave: key_bank.
interface key_bank_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] i_in;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_neg;
  logic [N_KEYS-1:0] o_pos;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_rpt;
  logic              o_any;

  modport master (output i_in,
                  input  o_level, o_neg, o_pos, o_long, o_rpt, o_any);
  modport slave  (input  i_in,
                  output o_level, o_neg, o_pos, o_long, o_rpt, o_any);
endinterface

// File: rtl/key_bank.sv
// key_bank: multi-channel push-button front end. Each channel has a 2-flop
// synchroniser, a debounce filter, press/release pulses, long-press detection
// and optional auto-repeat.
// Build option: define KEY_BANK_REPEAT_EN to compile in auto-repeat (o_rpt).
// Without it o_rpt is tied to 0, but HELD is still entered and o_long fires.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-low reset
//   kb     key_bank_if.slave (i_in in; o_level/o_neg/o_pos/o_long/o_rpt/o_any out)

module key_bank_ch #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
  parameter logic [23:0] LONG_CYC     = 24'd6000000,
  parameter logic [23:0] REPEAT_CYC   = 24'd1200000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_neg,
  output logic o_pos,
  output logic o_long,
  output logic o_rpt
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(LONG_CYC) + 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 16'd1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_CYC - 24'd1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} st_e;

  st_e           st_q;
  logic [1:0]    sync_q;
  logic          level_q, neg_q, pos_q, long_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q;
  logic          p, mism, acc;

  // Normalise so 1 always means pressed; sync flops reset to "released".
  assign p    = ACTIVE_LOW ? ~i_pin : i_pin;
  assign mism = sync_q[1] ^ level_q;
  // The D-th consecutive mismatched sample flips the level.
  assign acc  = mism && (dcnt_q == D_LAST);

  always_comb begin
    dcnt_d = dcnt_q + DW'(1);
    if (!mism || acc) dcnt_d = '0;
  end

`ifdef KEY_BANK_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC) + 1;
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 24'd1);
  logic [RW-1:0] rcnt_q;
  logic          rpt_q;
  assign o_rpt = rpt_q;
`else
  assign o_rpt = 1'b0;
`endif

  // In IDLE the level is 0, so acc is a press; in PRESS/HELD it is a release.
  // Release wins over a long/repeat event landing on the same edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q    <= IDLE;
      sync_q  <= '0;
      level_q <= 1'b0;
      neg_q   <= 1'b0;
      pos_q   <= 1'b0;
      long_q  <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
`ifdef KEY_BANK_REPEAT_EN
      rcnt_q  <= '0;
      rpt_q   <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], p};
      dcnt_q <= dcnt_d;
      neg_q  <= acc & ~level_q;
      pos_q  <= acc &  level_q;
      long_q <= 1'b0;
`ifdef KEY_BANK_REPEAT_EN
      rpt_q  <= 1'b0;
`endif
      if (acc) level_q <= ~level_q;
      case (st_q)
        IDLE: if (acc) begin
          st_q   <= PRESS;
          hcnt_q <= '0;
        end
        PRESS: begin
          if (acc) st_q <= IDLE;
          else if (hcnt_q == L_LAST) begin
            // hcnt stops here: HELD never counts it, so o_long fires once.
            st_q   <= HELD;
            long_q <= 1'b1;
`ifdef KEY_BANK_REPEAT_EN
            rcnt_q <= '0;
`endif
          end else hcnt_q <= hcnt_q + HW'(1);
        end
        HELD: begin
          if (acc) st_q <= IDLE;
`ifdef KEY_BANK_REPEAT_EN
          else if (rcnt_q == R_LAST) begin
            rpt_q  <= 1'b1;
            rcnt_q <= '0;
          end else rcnt_q <= rcnt_q + RW'(1);
`endif
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign o_level = level_q;
  assign o_neg   = neg_q;
  assign o_pos   = pos_q;
  assign o_long  = long_q;
endmodule

module key_bank #(
  parameter int          N_KEYS       = 4,
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
  parameter logic [23:0] LONG_CYC     = 24'd6000000,
  parameter logic [23:0] REPEAT_CYC   = 24'd1200000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  key_bank_if.slave   kb
);
  logic [N_KEYS-1:0] level_w, neg_w, pos_w, long_w, rpt_w;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_bank_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pin   (kb.i_in[g]),
      .o_level (level_w[g]),
      .o_neg   (neg_w[g]),
      .o_pos   (pos_w[g]),
      .o_long  (long_w[g]),
      .o_rpt   (rpt_w[g])
    );
  end

  assign kb.o_level = level_w;
  assign kb.o_neg   = neg_w;
  assign kb.o_pos   = pos_w;
  assign kb.o_long  = long_w;
  assign kb.o_rpt   = rpt_w;
  assign kb.o_any   = |level_w;
endmodule

// File: tb/tb_key_bank.sv
module tb_key_bank;
  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;
  localparam int R = 8;
`ifdef KEY_BANK_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pins = '1;
  bit           chk_en = 1'b0;
  int           n_chk = 0;
  int           n_pass = 0;

  key_bank_if #(.N_KEYS(N)) kb ();
  assign kb.i_in = pins;

  key_bank #(
    .N_KEYS       (N),
    .DEBOUNCE_CYC (16'(D)),
    .LONG_CYC     (24'(L)),
    .REPEAT_CYC   (24'(R)),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .kb    (kb)
  );

  always #5 clk = ~clk;

  // Behavioural model: a level flips when the last D synchronised samples
  // (pin delayed by two edges) all differ from it and none predate the last
  // flip. Long/repeat follow from the age of the current press.
  logic [31:0]  m_hv [N];
  logic         m_lvl [N];
  int           m_since [N];
  int           m_age [N];
  logic [N-1:0] e_lvl, e_neg, e_pos, e_long, e_rpt;

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] h;
    logic        l, acc;
    int          s, a;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        m_hv[c] <= '0; m_lvl[c] <= 1'b0; m_since[c] <= 1 << 20; m_age[c] <= 0;
      end
      e_lvl <= '0; e_neg <= '0; e_pos <= '0; e_long <= '0; e_rpt <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        h = {m_hv[c][30:0], ~pins[c]};
        s = m_since[c] + 1;
        a = m_age[c] + 1;
        l = m_lvl[c];
        acc = (s >= D);
        for (int k = 2; k <= D + 1; k++) if (h[k] == l) acc = 1'b0;
        e_neg[c]  <= acc & ~l;
        e_pos[c]  <= acc & l;
        e_long[c] <= !acc && l && (a == L);
        e_rpt[c]  <= RPT_EN && !acc && l && (a > L) && ((a - L) % R == 0);
        if (acc) begin l = ~l; s = 0; a = 0; end
        m_hv[c] <= h; m_since[c] <= s; m_age[c] <= a; m_lvl[c] <= l;
        e_lvl[c] <= l;
      end
    end
  end

  wire [20:0] outs = {kb.o_level, kb.o_neg, kb.o_pos, kb.o_long, kb.o_rpt, kb.o_any};
  wire [20:0] exps = {e_lvl, e_neg, e_pos, e_long, e_rpt, |e_lvl};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) if (chk_en) chk("cycle", 32'(outs), 32'(exps));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  logic [N-1:0] rpt_exp;
  int           hold [N];

  initial begin
    rpt_exp = RPT_EN ? 4'b0100 : 4'b0000;
    tick(2);
    chk_en = 1'b1;
    chk("reset_outs", 32'(outs), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(5);

    // clean press on ch0
    pins[0] = 1'b0;
    tick(9);  chk("press_early", kb.o_neg, 4'b0000);
    tick(1);  chk("press_neg", kb.o_neg, 4'b0001);
    chk("press_lvl", kb.o_level, 4'b0001);
    chk("press_any", kb.o_any, 1);
    chk("model_neg", e_neg, 4'b0001);
    tick(1);  chk("neg_width", kb.o_neg, 4'b0000);
    tick(9);
    pins[0] = 1'b1;
    tick(9);  chk("rel_early", kb.o_pos, 4'b0000);
    tick(1);  chk("rel_pos", kb.o_pos, 4'b0001);
    chk("rel_lvl", kb.o_level, 4'b0000);
    tick(5);

    // bounce on ch1: 3, 5, 7 low separated by 2 high
    pins[1] = 1'b0; tick(3); pins[1] = 1'b1; tick(2);
    pins[1] = 1'b0; tick(5); pins[1] = 1'b1; tick(2);
    pins[1] = 1'b0; tick(7); pins[1] = 1'b1; tick(2);
    chk("bounce_lvl", kb.o_level, 4'b0000);
    pins[1] = 1'b0;
    tick(9);  chk("bounce_early", kb.o_neg, 4'b0000);
    tick(1);  chk("bounce_neg", kb.o_neg, 4'b0010);
    pins[1] = 1'b1;
    tick(12);

    // long press / repeat on ch2, held 70 cycles
    pins[2] = 1'b0;
    tick(10); chk("long_neg", kb.o_neg, 4'b0100);
    tick(32); chk("long_fire", kb.o_long, 4'b0100);
    chk("model_long", e_long, 4'b0100);
    tick(1);  chk("long_width", kb.o_long, 4'b0000);
    tick(7);  chk("rpt1", kb.o_rpt, 32'(rpt_exp));
    tick(8);  chk("rpt2", kb.o_rpt, 32'(rpt_exp));
    tick(8);  chk("rpt3", kb.o_rpt, 32'(rpt_exp));
    tick(4);
    pins[2] = 1'b1;
    tick(9);  chk("held_rel_early", kb.o_pos, 4'b0000);
    tick(1);  chk("held_rel_pos", kb.o_pos, 4'b0100);
    tick(10); chk("no_rpt_after", kb.o_rpt, 4'b0000);
    tick(5);

    // all channels at once, then async reset while held
    pins = '0;
    tick(10); chk("sim_neg", kb.o_neg, 4'b1111);
    chk("sim_any", kb.o_any, 1);
    tick(36);
    rst = 1'b0;
    #1 chk("rst_async", 32'(outs), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(9);  chk("rst_early", kb.o_neg, 4'b0000);
    tick(1);  chk("rst_neg2", kb.o_neg[2], 1);
    chk("rst_nopos", kb.o_pos, 4'b0000);
    pins = '1;
    tick(12);

    // random pins, occasional long holds, one mid-run reset
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 30);
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          pins[c] = ~pins[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 90)
                                                : $urandom_range(1, 12);
        end
      end
      if (t == 1500) rst = 1'b0;
      if (t == 1503) rst = 1'b1;
      tick(1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
